mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the single-port unified instruction/data memory. Master 0 is the multi-cycle CPU (fetch plus load/store). Master 1 is a DMA/program-loader port. The block latches one request at a time and drives the memory's wd/address/we inputs. It captures the combinational read data and returns a one-cycle ack with registered rdata. Round-robin or fixed-priority selection is chosen by parameter; master 1 may lock the port for bounded bursts.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: two-master arbiter in front of a single-port, combinational-read memory.
// IDLE picks and latches one request, ACCESS drives the memory for one cycle, ack follows.
module mem_port_arbiter #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd,
    output logic        busy
);

    localparam int unsigned AW    = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_last_grant;
    logic             r_gnt;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_wd;
    logic [AW-1:0]    r_rdata;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_m0_ack;
    logic             r_m1_ack;
    logic             r_m0_err;
    logic             r_m1_err;

    logic [CNT_W-1:0] w_burst_nxt;
    logic [CNT_W:0]   w_burst_inc;
    logic             w_elig0;
    logic             w_elig1;
    logic             w_hold;
    logic             w_grant;
    logic             w_win;
    logic             w_access;
    logic             w_aligned;
    logic             w_wr_err;

    assign w_access    = (r_state == S_ACCESS);
    assign w_aligned   = (r_addr[1:0] == 2'b00);
    assign w_wr_err    = r_we && !w_aligned;

    // A master is not re-served in its own ack cycle.
    assign w_elig0     = m0_req && !r_m0_ack;
    assign w_elig1     = m1_req && !r_m1_ack;

    // Active burst keeps the port reserved for master 1 while it holds lock.
    assign w_hold      = m1_lock && (r_burst_cnt != '0)
                         && (r_burst_cnt < CNT_W'(MAX_BURST));
    assign w_burst_inc = (CNT_W+1)'(r_burst_cnt) + (CNT_W+1)'(1);

    // Next state and winner selection; w_win=1 means master 1.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hold) begin
                    w_grant = w_elig1;
                    w_win   = 1'b1;
                end else if (w_elig0 && w_elig1) begin
                    w_grant = 1'b1;
                    w_win   = (FIXED_PRIO != 0) ? 1'b0 : !r_last_grant;
                end else begin
                    w_grant = w_elig0 || w_elig1;
                    w_win   = !w_elig0;
                end
                if (w_grant) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Burst counter clears on reaching MAX_BURST so master 0 gets the next slot.
    always_comb begin
        w_burst_nxt = r_burst_cnt;
        if (w_grant) begin
            if (w_win && m1_lock) begin
                if (w_burst_inc >= (CNT_W+1)'(MAX_BURST)) begin
                    w_burst_nxt = '0;
                end else begin
                    w_burst_nxt = w_burst_inc[CNT_W-1:0];
                end
            end else begin
                w_burst_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, completion capture and grant history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wd         <= '0;
            r_rdata      <= '0;
            r_burst_cnt  <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
        end else begin
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
            r_burst_cnt <= w_burst_nxt;
            if (w_grant) begin
                r_gnt  <= w_win;
                r_we   <= w_win ? m1_we    : m0_we;
                r_addr <= w_win ? m1_addr  : m0_addr;
                r_wd   <= w_win ? m1_wdata : m0_wdata;
            end
            if (w_access) begin
                r_rdata      <= mem_rd;
                r_last_grant <= r_gnt;
                if (r_gnt) begin
                    r_m1_ack <= 1'b1;
                    r_m1_err <= w_wr_err;
                end else begin
                    r_m0_ack <= 1'b1;
                    r_m0_err <= w_wr_err;
                end
            end
        end
    end

    // Write strobe derives only from the async-reset state, so reset kills it at once.
    assign mem_we   = w_access && r_we && w_aligned;
    assign mem_addr = r_addr;
    assign mem_wd   = r_wd;
    assign busy     = w_access;
    assign rdata    = r_rdata;
    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_err   = r_m0_err;
    assign m1_err   = r_m1_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter: round-robin and fixed-priority instances driven by identical master
// streams, each checked every cycle against a transaction-level arbitration/memory model.
module tb_mem_port_arbiter;

    localparam int unsigned MAXB   = 3;
    localparam int unsigned MWORDS = 1024;

    typedef struct packed {
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wd;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_load;

    logic        m0_req[2], m0_we[2], m0_ack[2], m0_err[2];
    logic        m1_req[2], m1_we[2], m1_lock[2], m1_ack[2], m1_err[2];
    logic        mem_we[2], busy[2];
    logic [31:0] m0_addr[2], m0_wdata[2], m1_addr[2], m1_wdata[2];
    logic [31:0] rdata[2], mem_addr[2], mem_wd[2], mem_rd[2];
    logic [31:0] bmem[2][MWORDS];

    // Reference model state (index d: 0 = round-robin, 1 = fixed priority)
    logic        x_acc[2], x_gnt[2], x_we[2], x_last[2];
    logic [31:0] x_addr[2], x_wd[2], x_rdata[2];
    logic        x_ack[2][2], x_err[2][2];
    int          x_left[2];
    logic [31:0] mmem[2][MWORDS];

    txn_t        q[4][$];
    logic [15:0] ord[2];
    int          nack[2];
    int          n_pass;
    int          n_total;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.FIXED_PRIO(g), .MAX_BURST(MAXB)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
            .m0_ack(m0_ack[g]), .m0_err(m0_err[g]),
            .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_lock(m1_lock[g]), .m1_addr(m1_addr[g]),
            .m1_wdata(m1_wdata[g]), .m1_ack(m1_ack[g]), .m1_err(m1_err[g]),
            .rdata(rdata[g]), .mem_addr(mem_addr[g]), .mem_wd(mem_wd[g]), .mem_we(mem_we[g]),
            .mem_rd(mem_rd[g]), .busy(busy[g])
        );
        assign mem_rd[g] = bmem[g][mem_addr[g][11:2]];
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 60) return 32'h2042_0003;
        return (32'(i) * 32'h0001_0003) ^ 32'h5A00_0000;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_load) begin
                for (int i = 0; i < MWORDS; i++) bmem[d][i] <= init_word(i);
            end else if (mem_we[d]) begin
                bmem[d][mem_addr[d][11:2]] <= mem_wd[d];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic txn_t mk(input logic we, input logic lock, input logic [31:0] addr,
                                input logic [31:0] wd);
        txn_t t;
        t.we = we; t.lock = lock; t.addr = addr; t.wd = wd;
        return t;
    endfunction

    task automatic push(input int m, input txn_t t);
        for (int d = 0; d < 2; d++) q[2*d+m].push_back(t);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            x_acc[d] = 1'b0; x_gnt[d] = 1'b0; x_we[d] = 1'b0; x_last[d] = 1'b1;
            x_addr[d] = '0; x_wd[d] = '0; x_rdata[d] = '0; x_left[d] = 0;
            for (int m = 0; m < 2; m++) begin
                x_ack[d][m] = 1'b0; x_err[d][m] = 1'b0;
            end
        end
    endtask

    // One clock of the model: complete an access, or decide who is served next.
    task automatic model_edge(input int d);
        logic e0, e1, serve, to_m1, mis;
        int   idx;
        if (x_acc[d]) begin
            idx = int'(x_addr[d][11:2]);
            mis = x_we[d] && (x_addr[d][1:0] != 2'b00);
            x_rdata[d] = mmem[d][idx];
            if (x_we[d] && !mis) mmem[d][idx] = x_wd[d];
            x_ack[d][0] = !x_gnt[d];  x_ack[d][1] = x_gnt[d];
            x_err[d][0] = !x_gnt[d] && mis;
            x_err[d][1] = x_gnt[d] && mis;
            x_last[d] = x_gnt[d];
            x_acc[d] = 1'b0;
        end else begin
            e0 = m0_req[d] && !x_ack[d][0];
            e1 = m1_req[d] && !x_ack[d][1];
            for (int m = 0; m < 2; m++) begin
                x_ack[d][m] = 1'b0; x_err[d][m] = 1'b0;
            end
            if (x_left[d] > 0 && m1_lock[d]) begin
                serve = e1; to_m1 = 1'b1;
            end else if (e0 && e1) begin
                serve = 1'b1;
                to_m1 = (d == 1) ? 1'b0 : (x_last[d] == 1'b0);
            end else begin
                serve = e0 || e1; to_m1 = e1 && !e0;
            end
            if (serve) begin
                x_acc[d]  = 1'b1;
                x_gnt[d]  = to_m1;
                x_we[d]   = to_m1 ? m1_we[d] : m0_we[d];
                x_addr[d] = to_m1 ? m1_addr[d] : m0_addr[d];
                x_wd[d]   = to_m1 ? m1_wdata[d] : m0_wdata[d];
                if (!to_m1 || !m1_lock[d]) x_left[d] = 0;
                else x_left[d] = (x_left[d] > 0) ? x_left[d] - 1 : int'(MAXB) - 1;
            end
        end
    endtask

    task automatic check_outputs(input int d);
        check($sformatf("flags_d%0d", d),
              64'({m0_ack[d], m1_ack[d], m0_err[d], m1_err[d], busy[d], mem_we[d]}),
              64'({x_ack[d][0], x_ack[d][1], x_err[d][0], x_err[d][1], x_acc[d],
                   x_acc[d] && x_we[d] && (x_addr[d][1:0] == 2'b00)}));
        check($sformatf("rdata_d%0d", d), 64'(rdata[d]), 64'(x_rdata[d]));
        check($sformatf("mem_bus_d%0d", d), {mem_addr[d], mem_wd[d]}, {x_addr[d], x_wd[d]});
    endtask

    // Masters hold a request until acked, drop it in the ack cycle, then present the next.
    task automatic drive_masters();
        txn_t t;
        for (int d = 0; d < 2; d++) begin
            if (m0_req[d] && m0_ack[d]) begin
                void'(q[2*d].pop_front());
                m0_req[d] = 1'b0;
            end else if (!m0_req[d] && !m0_ack[d] && q[2*d].size() > 0) begin
                t = q[2*d][0];
                m0_req[d] = 1'b1; m0_we[d] = t.we; m0_addr[d] = t.addr; m0_wdata[d] = t.wd;
            end
            if (m1_req[d] && m1_ack[d]) begin
                void'(q[2*d+1].pop_front());
                m1_req[d] = 1'b0;
            end else if (!m1_req[d] && !m1_ack[d] && q[2*d+1].size() > 0) begin
                t = q[2*d+1][0];
                m1_req[d] = 1'b1; m1_we[d] = t.we; m1_addr[d] = t.addr; m1_wdata[d] = t.wd;
            end
            m1_lock[d] = (q[2*d+1].size() > 0) ? q[2*d+1][0].lock : 1'b0;
        end
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) model_edge(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_outputs(d);
        drive_masters();
    endtask

    task automatic record();
        for (int d = 0; d < 2; d++) begin
            if (m0_ack[d]) begin ord[d] = {ord[d][14:0], 1'b0}; nack[d]++; end
            if (m1_ack[d]) begin ord[d] = {ord[d][14:0], 1'b1}; nack[d]++; end
        end
    endtask

    task automatic clear_masters();
        for (int i = 0; i < 4; i++) q[i].delete();
        for (int d = 0; d < 2; d++) begin
            m0_req[d] = 1'b0; m1_req[d] = 1'b0; m1_lock[d] = 1'b0;
            m0_we[d] = 1'b0; m1_we[d] = 1'b0;
            m0_addr[d] = '0; m1_addr[d] = '0; m0_wdata[d] = '0; m1_wdata[d] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_masters();
        repeat (2) @(posedge clk);
        #1 mem_load = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check_outputs(d);
    endtask

    function automatic txn_t rand_txn(input int m);
        logic [31:0] a;
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return mk(1'($urandom_range(0, 1)), (m == 1) ? ($urandom_range(0, 2) != 0) : 1'b0,
                  a, $urandom);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        n_pass = 0;
        n_total = 0;
        mem_load = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < MWORDS; i++) mmem[d][i] = init_word(i);
        do_reset();

        // Single read after reset
        push(0, mk(1'b0, 1'b0, 32'h0000_00F0, 32'h0));
        drive_masters();
        step();
        for (int d = 0; d < 2; d++) check("t1_mem_addr", 64'(mem_addr[d]), 64'h0000_00F0);
        step();
        for (int d = 0; d < 2; d++)
            check("t1_ack_rdata", 64'({m0_ack[d], m1_ack[d], rdata[d]}),
                  64'({1'b1, 1'b0, 32'h2042_0003}));
        repeat (2) step();

        // Simultaneous requests, then read-after-write
        do_reset();
        push(0, mk(1'b0, 1'b0, 32'h0000_0000, 32'h0));
        push(1, mk(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF));
        push(0, mk(1'b0, 1'b0, 32'h0000_0100, 32'h0));
        drive_masters();
        for (int c = 2; c <= 8; c++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if (c == 3) check("t2_m0_first", 64'({m0_ack[d], m1_ack[d]}), 64'b10);
                if (c == 5) check("t2_m1_second", 64'({m0_ack[d], m1_ack[d]}), 64'b01);
                if (c == 7) check("t2_raw", 64'({m0_ack[d], rdata[d]}),
                                  64'({1'b1, 32'hDEAD_BEEF}));
            end
        end

        // Contest after master 0 was served last: round-robin vs fixed priority
        do_reset();
        push(0, mk(1'b0, 1'b0, 32'h10, 32'h0));
        drive_masters();
        repeat (4) step();
        for (int d = 0; d < 2; d++) begin ord[d] = '0; nack[d] = 0; end
        push(0, mk(1'b0, 1'b0, 32'h20, 32'h0));
        push(0, mk(1'b0, 1'b0, 32'h24, 32'h0));
        push(1, mk(1'b0, 1'b0, 32'h30, 32'h0));
        push(1, mk(1'b0, 1'b0, 32'h34, 32'h0));
        drive_masters();
        repeat (10) begin step(); record(); end
        check("t3_rr_order", 64'({nack[0], ord[0]}), 64'({32'd4, 16'b1010}));
        check("t3_fp_order", 64'({nack[1], ord[1]}), 64'({32'd4, 16'b0101}));

        // Locked burst of four with MAX_BURST=3 while master 0 waits
        do_reset();
        for (int i = 0; i < 4; i++)
            push(1, mk(1'b1, 1'b1, 32'h200 + 32'(4*i), 32'hB000_0000 + 32'(i)));
        drive_masters();
        for (int d = 0; d < 2; d++) begin ord[d] = '0; nack[d] = 0; end
        step();
        push(0, mk(1'b0, 1'b0, 32'h200, 32'h0));
        repeat (14) begin step(); record(); end
        for (int d = 0; d < 2; d++)
            check("t4_lock_order", 64'({nack[d], ord[d]}), 64'({32'd5, 16'b11101}));

        // Misaligned write is rejected
        push(0, mk(1'b1, 1'b0, 32'h0000_0102, 32'h1234_5678));
        drive_masters();
        step();
        for (int d = 0; d < 2; d++) check("t5_no_we", 64'({busy[d], mem_we[d]}), 64'b10);
        step();
        for (int d = 0; d < 2; d++) check("t5_err", 64'({m0_ack[d], m0_err[d]}), 64'b11);
        step();
        for (int d = 0; d < 2; d++) check("t5_word", 64'(bmem[d][64]), 64'hDEAD_BEEF);

        // Reset in the middle of a write access
        push(1, mk(1'b1, 1'b0, 32'h0000_0104, 32'hCAFE_F00D));
        drive_masters();
        step();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            check("t6_abort", 64'({mem_we[d], busy[d], m1_ack[d]}), 64'b000);
        clear_masters();
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_outputs(d);
            check("t6_word", 64'(bmem[d][65]), 64'(init_word(65)));
        end
        repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++)
                if (q[m].size() < 3 && $urandom_range(0, 3) == 0) push(m, rand_txn(m));
            step();
        end
        repeat (40) step();
        for (int d = 0; d < 2; d++) begin
            bad = 0;
            for (int i = 0; i < MWORDS; i++) if (bmem[d][i] !== mmem[d][i]) bad++;
            check("mem_image", 64'(bad), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
